// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and status-byte helper for the SPI flash
// responder and flash_ctl.
package spi_flash_pkg;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_STATUS,
    ST_IGNORE
  } flash_state_t;

  // WIP is never set: writes complete in a single clk cycle.
  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus edge pulses in the clk domain.
// Edges are held off until the chain holds real pin samples after reset.
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s,
  output logic cs_s
);

  logic [2:0] sclk_sr;
  logic [2:0] cs_sr;
  logic [1:0] mosi_sr;
  logic [1:0] fill;
  logic       valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sr <= 3'b000;
      cs_sr   <= 3'b111;
      mosi_sr <= 2'b00;
      fill    <= 2'd0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_clk};
      cs_sr   <= {cs_sr[1:0], spi_cs};
      mosi_sr <= {mosi_sr[0], spi_mosi};
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // A CS held low across reset must not look like a fresh select.
  assign valid     = (fill == 2'd3);
  assign sclk_rise = valid &  sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = valid & ~sclk_sr[1] &  sclk_sr[2];
  assign cs_fall   = valid & ~cs_sr[1]   &  cs_sr[2];
  assign cs_rise   = valid &  cs_sr[1]   & ~cs_sr[2];
  assign mosi_s    = mosi_sr[1];
  assign cs_s      = cs_sr[1];

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder: WREN/READ/WRITE commands over an inferred byte memory.
// Define SPI_FLASH_RDSR_EN to enable the 0x05 read-status command.
//
// state     | meaning
// ST_IDLE   | deselected, waiting for CS fall
// ST_CMD    | receiving opcode byte
// ST_ADDR   | receiving 3 address bytes
// ST_READ   | streaming memory bytes out, address auto-increments
// ST_WRITE  | writing received bytes when wel is set
// ST_STATUS | repeating status byte
// ST_IGNORE | dropping bits until CS rise
module spi_flash_resp
  import spi_flash_pkg::*;
#(
  parameter int FLASH_ADDR_SZ = 11
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic wel,
  output logic selected
);

  localparam int DEPTH = 2 ** FLASH_ADDR_SZ;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, cs_s;

  spi_sync_edge u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s),
    .cs_s      (cs_s)
  );

  flash_state_t             state_q, state_d;
  logic [6:0]               shift_in;
  logic [2:0]               bit_cnt;
  logic [7:0]               shift_out;
  logic                     miso_q;
  logic [15:0]              addr_acc;
  logic [1:0]               addr_cnt;
  logic [FLASH_ADDR_SZ-1:0] addr_q;
  logic                     is_read_q;
  logic                     wel_q;
  logic [7:0]               rd_data;
  logic [7:0]               mem [DEPTH] = '{default: 8'hFF};

  logic       byte_done;
  logic [7:0] rx_byte;
  logic [23:0] addr_full;
  logic       addr_unused;
  logic       out_state;
  logic [7:0] out_byte;
  logic       mem_we;

  assign byte_done   = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte     = {shift_in, mosi_s};
  assign addr_full   = {addr_acc, rx_byte};
  assign addr_unused = ^addr_full[23:FLASH_ADDR_SZ];
  assign out_state   = (state_q == ST_READ) || (state_q == ST_STATUS);
  assign out_byte    = (state_q == ST_STATUS) ? status_byte(wel_q) : rd_data;
  assign mem_we      = (state_q == ST_WRITE) && byte_done && wel_q;

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              CMD_READ, CMD_WRITE: state_d = ST_ADDR;
`ifdef SPI_FLASH_RDSR_EN
              CMD_RDSR:            state_d = ST_STATUS;
`else
              CMD_RDSR:            state_d = ST_IGNORE;
`endif
              default:             state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (byte_done && addr_cnt == 2'd2) state_d = is_read_q ? ST_READ : ST_WRITE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_in  <= '0;
      bit_cnt   <= '0;
      shift_out <= '0;
      miso_q    <= 1'b0;
      addr_acc  <= '0;
      addr_cnt  <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      wel_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cs_fall || cs_rise) begin
        shift_in <= '0;
        bit_cnt  <= '0;
        addr_cnt <= '0;
      end else if (sclk_rise) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (state_q == ST_CMD && byte_done) begin
        is_read_q <= (rx_byte == CMD_READ);
        if (rx_byte == CMD_WREN) wel_q <= 1'b1;
      end
      if (state_q == ST_ADDR && byte_done) begin
        addr_cnt <= addr_cnt + 2'd1;
        addr_acc <= addr_full[15:0];
        if (addr_cnt == 2'd2) addr_q <= addr_full[FLASH_ADDR_SZ-1:0];
      end
      if ((state_q == ST_READ || state_q == ST_WRITE) && byte_done) addr_q <= addr_q + 1'b1;
      if (state_q == ST_WRITE && cs_rise) wel_q <= 1'b0;
      // bit_cnt==0 on a fall means the next byte's MSB is due before the coming rise.
      if (out_state && sclk_fall) begin
        if (bit_cnt == 3'd0) begin
          miso_q    <= out_byte[7];
          shift_out <= {out_byte[6:0], 1'b0};
        end else begin
          miso_q    <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end else if (!out_state) begin
        miso_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= rx_byte;
    rd_data <= mem[addr_q];
  end

  assign spi_miso = miso_q & out_state;
  assign wel      = wel_q;
  assign selected = ~cs_s;

endmodule
